// File: rtl/hit_index_serializer.sv
// hit_index_serializer
//   Expands a hit mask into a serial stream of set-bit indices, lowest
//   index first, one index per output beat. Each burst also carries the
//   total hit count and an empty flag. An all-zero mask still produces a
//   single dummy beat so downstream framing always sees a closing beat.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   in_valid   in_word holds a mask
//   in_ready   block can accept a mask (IDLE and not in reset)
//   in_word    hit mask, bit i set = hit on channel i
//   out_valid  current beat is valid
//   out_ready  downstream takes the current beat
//   out_index  index of the lowest remaining set bit
//   out_last   current beat is the final beat of the mask
//   out_count  popcount of the accepted mask
//   out_empty  accepted mask was zero
module hit_index_serializer #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic [CNT_W-1:0] out_count,
    output logic             out_empty
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_clr;
    logic [CNT_W-1:0] pop;
    logic [IDX_W-1:0] low_idx;

    // Population count of the incoming mask, latched on accept.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + CNT_W'(in_word[i]);
        end
    end

    // Priority encoder: scanning from the top lets the lowest set bit win.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Pending mask with its lowest set bit removed; guarded so pend-1
    // never wraps on an empty mask.
    assign pend_clr = (pend != '0) ? (pend & (pend - WIDTH'(1))) : '0;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == EMIT);
    assign out_index = (state == EMIT) ? low_idx : '0;
    // Last beat when at most one bit remains (covers the empty-mask beat).
    assign out_last  = (state == EMIT) && (pend_clr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            out_count <= '0;
            out_empty <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pend      <= in_word;
                        out_count <= pop;
                        out_empty <= (in_word == '0);
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pend <= pend_clr;
                        if (out_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hit_index_serializer.sv
// tb_hit_index_serializer
//   Directed scenario tasks plus a randomized run against a queue-based
//   reference model. Inputs change and outputs are sampled on the falling
//   edge, so every sample reflects the state after the preceding rising edge.
module tb_hit_index_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic        out_last;
    logic [4:0]  out_count;
    logic        out_empty;

    int checks = 0;
    int errors = 0;

    hit_index_serializer #(.WIDTH(16), .IDX_W(4), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .out_count (out_count),
        .out_empty (out_empty)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_word = 16'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_index !== 4'd0 || out_last !== 1'b0 ||
            out_count !== 5'd0 || out_empty !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: valid=%b ready=%b idx=%0d last=%b cnt=%0d empty=%b, required all 0",
                     out_valid, in_ready, out_index, out_last, out_count, out_empty);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_two_bits();
        in_valid = 1'b1; in_word = 16'h8001; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd0 || out_last !== 1'b0 || out_count !== 5'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL two_bits_beat0: valid=%b idx=%0d last=%b cnt=%0d in_ready=%b, required 1 0 0 2 0",
                     out_valid, out_index, out_last, out_count, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd15 || out_last !== 1'b1 || out_count !== 5'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL two_bits_beat1: valid=%b idx=%0d last=%b cnt=%0d in_ready=%b, required 1 15 1 2 0",
                     out_valid, out_index, out_last, out_count, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL two_bits_idle: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_empty();
        in_valid = 1'b1; in_word = 16'h0000; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd0 || out_last !== 1'b1 || out_empty !== 1'b1 || out_count !== 5'd0) begin
            errors++;
            $display("[TB] FAIL empty_beat: valid=%b idx=%0d last=%b empty=%b cnt=%0d, required 1 0 1 1 0",
                     out_valid, out_index, out_last, out_empty, out_count);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL empty_idle: valid=%b in_ready=%b empty=%b, required 0 1 1", out_valid, in_ready, out_empty);
        end
    endtask

    // Full mask with a stuttering consumer; a second mask is offered during
    // the burst and must only be taken once the block is idle again.
    task automatic test_full_stall();
        int k = 0;
        int cyc = 0;
        in_valid = 1'b1; in_word = 16'hFFFF; out_ready = 1'b0;
        @(negedge clk);
        in_word = 16'h0001;
        while (k < 16 && cyc < 60) begin
            checks++;
            if (out_valid !== 1'b1 || out_index !== 4'(k) || out_last !== (k == 15) ||
                out_count !== 5'd16 || out_empty !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL full_beat%0d: valid=%b idx=%0d last=%b cnt=%0d empty=%b in_ready=%b, required 1 %0d %b 16 0 0",
                         k, out_valid, out_index, out_last, out_count, out_empty, in_ready, k, (k == 15));
            end
            out_ready = (cyc % 2 == 0);
            if (out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (k != 16) begin
            errors++;
            $display("[TB] FAIL full_beat_total: got %0d beats, required 16", k);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_return_idle: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd0 || out_last !== 1'b1 || out_count !== 5'd1 || out_empty !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_mask_beat: valid=%b idx=%0d last=%b cnt=%0d empty=%b, required 1 0 1 1 0",
                     out_valid, out_index, out_last, out_count, out_empty);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_mask_done: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1; in_word = 16'h00F0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd4 || out_count !== 5'd4) begin
            errors++;
            $display("[TB] FAIL midrst_idx4: valid=%b idx=%0d cnt=%0d, required 1 4 4", out_valid, out_index, out_count);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd5) begin
            errors++;
            $display("[TB] FAIL midrst_idx5: valid=%b idx=%0d, required 1 5", out_valid, out_index);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_index !== 4'd0 || out_last !== 1'b0 || out_count !== 5'd0 ||
            out_empty !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_cleared: valid=%b idx=%0d last=%b cnt=%0d empty=%b in_ready=%b, required all 0",
                     out_valid, out_index, out_last, out_count, out_empty, in_ready);
        end
        rst = 1'b0;
        in_valid = 1'b1; in_word = 16'h0003;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd0 || out_last !== 1'b0 || out_count !== 5'd2) begin
            errors++;
            $display("[TB] FAIL postrst_idx0: valid=%b idx=%0d last=%b cnt=%0d, required 1 0 0 2",
                     out_valid, out_index, out_last, out_count);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd1 || out_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL postrst_idx1: valid=%b idx=%0d last=%b, required 1 1 1", out_valid, out_index, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL postrst_idle: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    // Reference model: a queue of expected indices for the current burst.
    task automatic test_random();
        int        q[$];
        bit        busy = 1'b0;
        int        exp_cnt = 0;
        bit        exp_empty = 1'b0;
        logic [15:0] m;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            checks++;
            if (out_valid !== busy || in_ready !== !busy ||
                (busy && (out_index !== 4'(q[0]) || out_last !== (q.size() == 1) ||
                          out_count !== 5'(exp_cnt) || out_empty !== exp_empty))) begin
                errors++;
                $display("[TB] FAIL random_cyc%0d: valid=%b in_ready=%b idx=%0d last=%b cnt=%0d empty=%b, required valid=%b idx=%0d last=%b cnt=%0d empty=%b",
                         cyc, out_valid, in_ready, out_index, out_last, out_count, out_empty,
                         busy, busy ? q[0] : 0, busy && q.size() == 1, exp_cnt, exp_empty);
            end
            // Hold an unaccepted mask steady; otherwise pick fresh stimulus.
            if (!(in_valid && busy)) begin
                in_valid = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 3))
                    0:       in_word = 16'h0000;
                    1:       in_word = 16'h0001 << $urandom_range(0, 15);
                    2:       in_word = 16'($urandom);
                    default: in_word = 16'hFFFF;
                endcase
            end
            out_ready = ($urandom_range(0, 1) == 1);
            if (!busy) begin
                if (in_valid) begin
                    m = in_word;
                    q.delete();
                    exp_cnt = 0;
                    for (int i = 0; i < 16; i++) begin
                        if (m[i]) begin
                            q.push_back(i);
                            exp_cnt++;
                        end
                    end
                    exp_empty = (m == 16'h0);
                    if (exp_empty) q.push_back(0);
                    busy = 1'b1;
                end
            end else if (out_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) busy = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_two_bits();
        test_empty();
        test_full_stall();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
